// File: rtl/fir_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : fir_ctrl_fsm
// Brief    : FIR control FSM. It writes samples to the circular buffer and
//            sequences the tap addresses and accumulator controls.
//            Optional macro FIR_OVERRUN_EN adds a sticky overrun output.
// Revision : 1.0
// ============================================================================
module fir_ctrl_fsm #(
  parameter int  N_TAPS  = 16,
  parameter int  MUL_LAT = 1,
  localparam int ADDR_W  = $clog2(N_TAPS)
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              probka_valid,
  output logic              probka_ready,
  output logic              FSM_zapis_probki,
  output logic [ADDR_W-1:0] adres_probki,
  output logic [ADDR_W-1:0] adres_wsp,
  output logic              FSM_reset_Acc,
  output logic              FSM_Acc_en,
  output logic              FSM_Acc_zapis,
  output logic              busy,
  output logic              probka_gotowa
`ifdef FIR_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int              c_ADDR_X     = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] c_K_LAST   = ADDR_W'(N_TAPS - 1);
  localparam logic [ADDR_W:0]   c_NTAPS_X  = c_ADDR_X'(N_TAPS);
  localparam logic [2:0]        c_DRN_LAST = 3'(MUL_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_SAVE  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_k;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [2:0]        r_dcnt;
  logic              r_ready;
  logic              r_busy;
  logic              r_clr;
  logic              r_save;
  logic              r_done;

  logic              w_accept;
  logic              w_run;
  logic [ADDR_W:0]   w_rd_ext;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W-1:0] w_wr_next;

  assign w_accept = r_ready & probka_valid;
  assign w_run    = (r_state == S_RUN);

  // Explicit modular subtraction so non-power-of-two tap counts wrap correctly.
  assign w_rd_ext  = (r_wr_ptr >= r_k) ? ({1'b0, r_wr_ptr} - {1'b0, r_k})
                                       : ({1'b0, r_wr_ptr} + c_NTAPS_X - {1'b0, r_k});
  assign w_rd_addr = w_rd_ext[ADDR_W-1:0];
  assign w_wr_next = (r_wr_ptr == c_K_LAST) ? '0 : r_wr_ptr + 1'b1;

  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_k      <= '0;
      r_wr_ptr <= '0;
      r_dcnt   <= '0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_clr    <= 1'b0;
      r_save   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_clr  <= 1'b0;
      r_save <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (probka_valid) begin
            r_state <= S_CLR;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_clr   <= 1'b1;
          end
        end
        S_CLR: begin
          r_k     <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (r_k == c_K_LAST) begin
            if (MUL_LAT == 0) begin
              r_state <= S_SAVE;
              r_save  <= 1'b1;
            end else begin
              r_state <= S_DRAIN;
              r_dcnt  <= '0;
            end
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_dcnt == c_DRN_LAST) begin
            r_state <= S_SAVE;
            r_save  <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        S_SAVE: begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_wr_ptr <= w_wr_next;
          r_ready  <= 1'b1;
          r_busy   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // The valid pipe mirrors the multiplier latency so accumulation lines up with data.
  generate
    if (MUL_LAT == 0) begin : g_lat0
      assign FSM_Acc_en = w_run;
    end else begin : g_pipe
      logic [MUL_LAT-1:0] r_vpipe;
      always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
          r_vpipe <= '0;
        end else begin
          r_vpipe <= MUL_LAT'({r_vpipe, w_run});
        end
      end
      assign FSM_Acc_en = r_vpipe[MUL_LAT-1];
    end
  endgenerate

  always_comb begin
    adres_wsp    = '0;
    adres_probki = w_rd_addr;
    if (r_state == S_IDLE) begin
      adres_probki = r_wr_ptr;
    end else if ((r_state == S_RUN) || (r_state == S_DRAIN)) begin
      adres_wsp = r_k;
    end
  end

  assign probka_ready     = r_ready;
  assign busy             = r_busy;
  assign FSM_zapis_probki = w_accept;
  assign FSM_reset_Acc    = r_clr;
  assign FSM_Acc_zapis    = r_save;
  assign probka_gotowa    = r_done;

`ifdef FIR_OVERRUN_EN
  logic r_overrun;
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (w_accept && r_overrun) begin
      r_overrun <= 1'b0;
    end else if (probka_valid && r_busy) begin
      r_overrun <= 1'b1;
    end
  end
  assign overrun = r_overrun;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl_fsm.sv
`default_nettype none
// Bench for fir_ctrl_fsm: three configurations in lockstep, checked every cycle
// against a per-sample timeline model, plus literal expectations and a FIR datapath.
module tb_fir_ctrl_fsm;

  logic clk_b        = 1'b0;
  logic rst          = 1'b1;
  logic probka_valid = 1'b0;
  always #5 clk_b = ~clk_b;

  logic       rdy0, zap0, rac0, en0, sav0, bsy0, got0;
  logic [1:0] apr0, aw0;
  logic       rdy1, zap1, rac1, en1, sav1, bsy1, got1;
  logic [1:0] apr1, aw1;
  logic       rdy2, zap2, rac2, en2, sav2, bsy2, got2;
  logic [2:0] apr2, aw2;
  logic [2:0] o_ov;

`ifdef FIR_OVERRUN_EN
  logic ov0, ov1, ov2;
  assign o_ov = {ov2, ov1, ov0};
`else
  assign o_ov = 3'b000;
`endif

  fir_ctrl_fsm #(.N_TAPS(4), .MUL_LAT(1)) u_dut0 (
    .clk_b(clk_b), .rst(rst), .probka_valid(probka_valid), .probka_ready(rdy0),
    .FSM_zapis_probki(zap0), .adres_probki(apr0), .adres_wsp(aw0), .FSM_reset_Acc(rac0),
    .FSM_Acc_en(en0), .FSM_Acc_zapis(sav0), .busy(bsy0), .probka_gotowa(got0)
`ifdef FIR_OVERRUN_EN
    , .overrun(ov0)
`endif
  );

  fir_ctrl_fsm #(.N_TAPS(4), .MUL_LAT(0)) u_dut1 (
    .clk_b(clk_b), .rst(rst), .probka_valid(probka_valid), .probka_ready(rdy1),
    .FSM_zapis_probki(zap1), .adres_probki(apr1), .adres_wsp(aw1), .FSM_reset_Acc(rac1),
    .FSM_Acc_en(en1), .FSM_Acc_zapis(sav1), .busy(bsy1), .probka_gotowa(got1)
`ifdef FIR_OVERRUN_EN
    , .overrun(ov1)
`endif
  );

  fir_ctrl_fsm #(.N_TAPS(5), .MUL_LAT(3)) u_dut2 (
    .clk_b(clk_b), .rst(rst), .probka_valid(probka_valid), .probka_ready(rdy2),
    .FSM_zapis_probki(zap2), .adres_probki(apr2), .adres_wsp(aw2), .FSM_reset_Acc(rac2),
    .FSM_Acc_en(en2), .FSM_Acc_zapis(sav2), .busy(bsy2), .probka_gotowa(got2)
`ifdef FIR_OVERRUN_EN
    , .overrun(ov2)
`endif
  );

  logic [2:0] o_rdy, o_zap, o_rac, o_en, o_sav, o_bsy, o_got;
  logic [7:0] o_apr [3];
  logic [7:0] o_aw  [3];
  assign o_rdy = {rdy2, rdy1, rdy0};
  assign o_zap = {zap2, zap1, zap0};
  assign o_rac = {rac2, rac1, rac0};
  assign o_en  = {en2,  en1,  en0};
  assign o_sav = {sav2, sav1, sav0};
  assign o_bsy = {bsy2, bsy1, bsy0};
  assign o_got = {got2, got1, got0};
  assign o_apr[0] = {6'd0, apr0};
  assign o_apr[1] = {6'd0, apr1};
  assign o_apr[2] = {5'd0, apr2};
  assign o_aw[0]  = {6'd0, aw0};
  assign o_aw[1]  = {6'd0, aw1};
  assign o_aw[2]  = {5'd0, aw2};

  int cyc = 0;
  int phase = 0;
  int ph_start = 0;
  int rel = 0;
  int n_chk = 0;
  int n_pass = 0;
  always @(posedge clk_b) cyc <= cyc + 1;

  // FIR datapath around instance 0: sample RAM, ROM coef = addr+1, one product stage.
  int smp_tbl [16] = '{0: 10, default: 0};
  int ram [4] = '{default: 0};
  int prod = 0, acc = 0, res = 0, n_wr = 0;
  always @(posedge clk_b) begin
    if (zap0) begin
      ram[apr0] <= smp_tbl[n_wr];
      n_wr      <= n_wr + 1;
    end
    prod <= ram[apr0] * (int'(aw0) + 1);
    if (rac0) acc <= 0;
    else if (en0) acc <= acc + prod;
    if (sav0) res <= acc;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at t=%0t: got %0d, expected %0d", nm, $time, act, exp);
  endtask

  // Model: each accepted sample follows a fixed timeline of offsets from its accept cycle.
  int NT [3] = '{4, 4, 5};
  int ML [3] = '{1, 0, 3};
  int m_t  [3];
  int m_wp [3];
  int m_ov [3];

  task automatic model_cycle(input int i);
    int n, l, t, ea, ew;
    bit chk_addr;
    n = NT[i]; l = ML[i]; t = m_t[i];
    if (rst) begin
      chk($sformatf("u%0d_rst_rdy", i), int'(o_rdy[i]), 1);
      chk($sformatf("u%0d_rst_busy", i), int'(o_bsy[i]), 0);
      chk($sformatf("u%0d_rst_outs", i),
          int'({o_zap[i], o_rac[i], o_en[i], o_sav[i], o_got[i], o_ov[i]}), 0);
      chk($sformatf("u%0d_rst_addr", i), int'(o_apr[i]) + int'(o_aw[i]), 0);
      m_t[i] = -1; m_wp[i] = 0; m_ov[i] = 0;
    end else if (t < 0) begin
      chk($sformatf("u%0d_idle_rdy", i), int'(o_rdy[i]), 1);
      chk($sformatf("u%0d_idle_busy", i), int'(o_bsy[i]), 0);
      chk($sformatf("u%0d_zap", i), int'(o_zap[i]), int'(probka_valid));
      chk($sformatf("u%0d_idle_ctl", i), int'({o_rac[i], o_en[i], o_sav[i], o_got[i]}), 0);
      chk($sformatf("u%0d_wr_addr", i), int'(o_apr[i]), m_wp[i]);
`ifdef FIR_OVERRUN_EN
      chk($sformatf("u%0d_ov", i), int'(o_ov[i]), m_ov[i]);
`endif
      if (probka_valid) begin
        m_t[i] = 1;
        m_ov[i] = 0;
      end
    end else begin
      chk($sformatf("u%0d_rdy", i), int'(o_rdy[i]), 0);
      chk($sformatf("u%0d_busy", i), int'(o_bsy[i]), 1);
      chk($sformatf("u%0d_zap", i), int'(o_zap[i]), 0);
      chk($sformatf("u%0d_rstacc", i), int'(o_rac[i]), int'(t == 1));
      chk($sformatf("u%0d_acc_en", i), int'(o_en[i]), int'(t >= 2 + l && t <= n + 1 + l));
      chk($sformatf("u%0d_acc_zapis", i), int'(o_sav[i]), int'(t == n + 2 + l));
      chk($sformatf("u%0d_gotowa", i), int'(o_got[i]), int'(t == n + 3 + l));
`ifdef FIR_OVERRUN_EN
      chk($sformatf("u%0d_ov", i), int'(o_ov[i]), m_ov[i]);
`endif
      chk_addr = 1'b0; ea = 0; ew = 0;
      if (t >= 2 && t <= n + 1) begin
        chk_addr = 1'b1; ew = t - 2; ea = (m_wp[i] - ew + n) % n;
      end else if (t > n + 1 && t <= n + 1 + l) begin
        chk_addr = 1'b1; ew = n - 1; ea = (m_wp[i] - ew + n) % n;
      end
      if (chk_addr) begin
        chk($sformatf("u%0d_rd_addr", i), int'(o_apr[i]), ea);
        chk($sformatf("u%0d_coef_addr", i), int'(o_aw[i]), ew);
      end
      if (probka_valid) m_ov[i] = 1;
      m_t[i] = t + 1;
      if (m_t[i] == n + 4 + l) begin
        m_t[i] = -1;
        m_wp[i] = (m_wp[i] + 1) % n;
      end
    end
  endtask

  int rd1 [4] = '{0, 3, 2, 1};
  int rd2 [4] = '{1, 0, 3, 2};
  int wa  [5] = '{1, 2, 3, 0, 0};
  int fir_exp [5] = '{10, 20, 30, 40, 0};
  int n_got = 0;
  int n_abort = 0;

  task automatic literal_checks();
    if (phase == 1) begin
      if (rel == 0) begin
        chk("lit_first_zap", int'(zap0), 1);
        chk("lit_first_waddr", int'(apr0), 0);
      end
      if (rel == 1) chk("lit_clr", int'(rac0), 1);
      if (rel >= 2 && rel <= 5) begin
        chk("lit_rd_seq1", int'(apr0), rd1[rel-2]);
        chk("lit_coef_seq", int'(aw0), rel - 2);
        chk("lit_ml0_en", int'(en1), 1);
      end
      if (rel >= 11 && rel <= 14) chk("lit_rd_seq2", int'(apr0), rd2[rel-11]);
      if (rel <= 9) chk("lit_en_window", int'(en0), int'(rel >= 3 && rel <= 6));
      if (rel == 7) chk("lit_save", int'(sav0), 1);
      if (rel == 8) chk("lit_gotowa", int'(got0), 1);
      if (rel == 6) chk("lit_ml0_save", int'({sav1, en1}), 2);
      if (rel == 7) chk("lit_ml0_gotowa", int'(got1), 1);
      if (rel == 9 || rel == 18 || rel == 27 || rel == 36) begin
        chk("lit_b2b_zap", int'(zap0), 1);
        chk("lit_b2b_waddr", int'(apr0), wa[rel/9 - 1]);
      end
      if (got0) begin
        if (n_got < 5) chk("lit_fir_out", res, fir_exp[n_got]);
        n_got++;
      end
      if (rel == 60) chk("lit_fir_count", n_got, 5);
    end else if (phase == 2) begin
      if (rel == 0) chk("lit_p2_waddr", int'(apr0), 1);
      if (rel == 7) chk("lit_p2_save", int'(sav0), 1);
      if (rel == 8) chk("lit_p2_gotowa", int'(got0), 1);
      if (rel == 9) chk("lit_p2_ready", int'(rdy0), 1);
`ifdef FIR_OVERRUN_EN
      if (rel == 0) chk("lit_ov_sticky", int'(ov0), 1);
      if (rel == 1) chk("lit_ov_clear", int'(ov0), 0);
      if (rel == 3) chk("lit_ov_before", int'(ov0), 0);
      if (rel == 4) chk("lit_ov_set", int'(ov0), 1);
      if (rel == 10) chk("lit_ov_hold", int'(ov0), 1);
`endif
    end else if (phase == 3) begin
      if (rel == 0) begin
        chk("lit_p3_waddr", int'(apr0), 2);
        n_abort = 0;
      end
      if (rel == 4) begin
        chk("lit_abort_ready", int'(rdy0), 1);
        chk("lit_abort_outs", int'({bsy0, en0, rac0, apr0}), 0);
      end
      if (rel >= 4 && (sav0 || got0)) n_abort++;
      if (rel == 19) chk("lit_abort_no_save", n_abort, 0);
    end else if (phase == 4) begin
      if (rel == 0) chk("lit_p4_waddr", int'({zap0, apr0}), 4);
      if (rel == 8) chk("lit_p4_gotowa", int'(got0), 1);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_t[i] = -1; m_wp[i] = 0; m_ov[i] = 0;
    end
    forever begin
      @(negedge clk_b);
      rel = cyc - ph_start;
      for (int i = 0; i < 3; i++) model_cycle(i);
      literal_checks();
    end
  end

  initial begin
    repeat (3) @(posedge clk_b);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk_b);

    // Back-to-back samples with valid held high.
    #1 phase = 1; ph_start = cyc; probka_valid = 1'b1;
    repeat (45) @(posedge clk_b);
    #1 probka_valid = 1'b0;
    repeat (20) @(posedge clk_b);

    // One accept, then stray valid pulses at rel 3 and 5 while busy.
    #1 phase = 2; ph_start = cyc; probka_valid = 1'b1;
    @(posedge clk_b); #1 probka_valid = 1'b0;
    @(posedge clk_b);
    @(posedge clk_b); #1 probka_valid = 1'b1;
    @(posedge clk_b); #1 probka_valid = 1'b0;
    @(posedge clk_b); #1 probka_valid = 1'b1;
    @(posedge clk_b); #1 probka_valid = 1'b0;
    repeat (20) @(posedge clk_b);

    // Reset in the middle of RUN.
    #1 phase = 3; ph_start = cyc; probka_valid = 1'b1;
    @(posedge clk_b); #1 probka_valid = 1'b0;
    repeat (3) @(posedge clk_b);
    #1 rst = 1'b1;
    @(posedge clk_b); #1 rst = 1'b0;
    repeat (20) @(posedge clk_b);

    // First sample after the abort lands at write pointer 0.
    #1 phase = 4; ph_start = cyc; probka_valid = 1'b1;
    @(posedge clk_b); #1 probka_valid = 1'b0;
    repeat (15) @(posedge clk_b);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_ctrl_fsm.md
Name: fir_ctrl_fsm

Overview:
Control FSM for the FIR datapath. It accepts one input sample per handshake and writes it into the circular sample buffer. It then sequences N_TAPS coefficient/sample address pairs and drives the accumulator controls (FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis), compensating for the multiplier/adder latency. It sits between the sample input interface and the sample RAM, coefficient ROM and acc_module.

Parameters:
N_TAPS, 16, number of filter taps; >= 2, any integer (wrap handled explicitly, not by bit truncation).
MUL_LAT, 1, cycles from address issue to valid suma_wynik at the accumulator input; 0..4.
ADDR_W, $clog2(N_TAPS), localparam, width of buffer and coefficient addresses.

Ports:
clk_b  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
probka_valid  in  1  new input sample available this cycle.
probka_ready  out  1  FSM can accept a sample (high only in IDLE).
FSM_zapis_probki  out  1  write strobe to sample RAM at adres_probki.
adres_probki  out  ADDR_W  sample RAM address (write or read).
adres_wsp  out  ADDR_W  coefficient ROM address.
FSM_reset_Acc  out  1  clear accumulator.
FSM_Acc_en  out  1  accumulate suma_wynik.
FSM_Acc_zapis  out  1  latch Acc_out into FIR_probka_wynik.
busy  out  1  high in every state except IDLE.
probka_gotowa  out  1  one-cycle pulse: FIR_probka_wynik updated.

Behaviour:
- Reset: state=IDLE; wr_ptr=0; tap counter k=0; latency pipe cleared. All outputs 0 except probka_ready=1. Reset mid-operation aborts the current sample immediately. No SAVE is issued.
- States:
  - IDLE: probka_ready=1; adres_probki=wr_ptr. If probka_valid=1, assert FSM_zapis_probki this same cycle, then go to CLR.
  - CLR: FSM_reset_Acc=1 for one cycle; k<=0; go to RUN.
  - RUN: adres_wsp=k; adres_probki=(wr_ptr-k) mod N_TAPS (wr_ptr - k, plus N_TAPS if negative). Push a 1 into the MUL_LAT-deep valid pipe. k++. After k=N_TAPS-1, go to DRAIN, or to SAVE if MUL_LAT=0.
  - DRAIN: exactly MUL_LAT cycles; address outputs hold their last value; go to SAVE.
  - SAVE: FSM_Acc_zapis=1 for one cycle; go to DONE.
  - DONE: probka_gotowa=1; wr_ptr<=(wr_ptr+1) mod N_TAPS; go to IDLE.
- FSM_Acc_en = output of the valid pipe (the RUN push delayed by MUL_LAT cycles; combinational during RUN when MUL_LAT=0). It is never high in CLR or SAVE.
- Timing, with the accepted valid in cycle 0:
  - CLR in cycle 1.
  - RUN in cycles 2..N_TAPS+1.
  - FSM_Acc_en high for exactly N_TAPS consecutive cycles, 2+MUL_LAT..N_TAPS+1+MUL_LAT.
  - SAVE in cycle N_TAPS+2+MUL_LAT.
  - probka_gotowa in cycle N_TAPS+3+MUL_LAT.
- Throughput: next sample is accepted no earlier than the cycle after DONE.
- probka_valid while busy=1 is ignored. The sample is dropped and no state changes.
- Address outputs in CLR/SAVE/DONE are don't-care. FSM_zapis_probki is high only in the accepting IDLE cycle.

Optional Feature:
Macro FIR_OVERRUN_EN.
- Defined: adds output port overrun (1 bit), a sticky flag set on the cycle after any cycle with probka_valid=1 and busy=1. It is cleared only by rst or by a probka_valid accepted in IDLE while overrun=1. The clear is one cycle after acceptance and takes priority over a set in the same cycle.
- Undefined: no port; dropped samples are silent.

Test Plan:
- N_TAPS=4, MUL_LAT=1, first sample after reset, valid in cycle 0 -> FSM_zapis_probki at cycle 0 addr 0; FSM_reset_Acc cycle 1; adres_probki 0,3,2,1 and adres_wsp 0,1,2,3 in cycles 2-5; FSM_Acc_en cycles 3-6; FSM_Acc_zapis cycle 7; probka_gotowa cycle 8.
- Same config, 5 back-to-back samples (valid held high) -> accepted at cycles 0,9,18,27,36; write addresses 0,1,2,3,0; 2nd read sequence 1,0,3,2.
- N_TAPS=4, MUL_LAT=0 -> FSM_Acc_en in cycles 2-5, coincident with RUN; no DRAIN; SAVE cycle 6; probka_gotowa cycle 7.
- Valid pulses at cycles 3 and 5 while busy -> no state or pointer change; with FIR_OVERRUN_EN overrun=1 from cycle 4; next accepted sample clears it one cycle after acceptance.
- rst asserted in cycle 4 (mid-RUN) -> next edge outputs all 0, probka_ready=1, wr_ptr=0; no FSM_Acc_zapis or probka_gotowa for the aborted sample.
- Integrated with acc_module plus a MUL_LAT=1 product stage, coefficients 1,2,3,4 and samples 10,0,0,0 -> FIR_probka_wynik sequence 10,20,30,40.
